operand_aligner: RTL and testbench

//  Receiver for the per-channel operand interface of the arithmetic core (a/b/c/d, each with its own valid).

---
 rtl/operand_aligner_pkg.sv | 15 +
 rtl/operand_aligner_if.sv | 38 +++
 rtl/operand_aligner_chan_fifo.sv | 60 ++++++
 rtl/operand_aligner.sv | 83 ++++++++
 tb/tb_operand_aligner.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/operand_aligner_pkg.sv
// rtl/operand_aligner_pkg.sv - shared constants and types for the operand aligner
package operand_aligner_pkg;

    localparam int CH_NUM = 4;

    localparam int CH_A = 0;
    localparam int CH_B = 1;
    localparam int CH_C = 2;
    localparam int CH_D = 3;

    localparam int DEF_DATA_WIDTH = 32;

    typedef logic [DEF_DATA_WIDTH-1:0] operand_t;

endpackage

// File: rtl/operand_aligner_if.sv
// rtl/operand_aligner_if.sv - per-channel operand inputs and aligned tuple output bundle
interface operand_aligner_if
    import operand_aligner_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] a_i;
    logic [DATA_WIDTH-1:0] b_i;
    logic [DATA_WIDTH-1:0] c_i;
    logic [DATA_WIDTH-1:0] d_i;
    logic                  a_valid_i;
    logic                  b_valid_i;
    logic                  c_valid_i;
    logic                  d_valid_i;
    logic                  out_ready_i;
    logic                  clear_err_i;
    logic [DATA_WIDTH-1:0] a_o;
    logic [DATA_WIDTH-1:0] b_o;
    logic [DATA_WIDTH-1:0] c_o;
    logic [DATA_WIDTH-1:0] d_o;
    logic                  out_valid_o;
    logic [CH_NUM-1:0]     ovf_o;

    modport master (
        output a_i, b_i, c_i, d_i,
        output a_valid_i, b_valid_i, c_valid_i, d_valid_i,
        output out_ready_i, clear_err_i,
        input  a_o, b_o, c_o, d_o, out_valid_o, ovf_o
    );

    modport slave (
        input  a_i, b_i, c_i, d_i,
        input  a_valid_i, b_valid_i, c_valid_i, d_valid_i,
        input  out_ready_i, clear_err_i,
        output a_o, b_o, c_o, d_o, out_valid_o, ovf_o
    );

endinterface

// File: rtl/operand_aligner_chan_fifo.sv
// rtl/operand_aligner_chan_fifo.sv - single-channel synchronous FIFO with simultaneous push/pop
module chan_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic                        pop,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    output logic [DATA_WIDTH-1:0]       rd_data,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(DEPTH):0]      count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a word when a slot frees up in the same edge.
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    // Storage write; contents need no reset because count gates every read.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at power-of-two DEPTH.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/operand_aligner.sv
// rtl/operand_aligner.sv - buffers four operand channels and releases them as one aligned tuple
module operand_aligner
    import operand_aligner_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic               clk_i,
    input  logic               artsn_i,
    operand_aligner_if.slave   bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DATA_WIDTH-1:0] wr_data    [CH_NUM];
    logic [DATA_WIDTH-1:0] rd_data    [CH_NUM];
    logic [CW-1:0]         fifo_count [CH_NUM];
    logic [CH_NUM-1:0]     push;
    logic [CH_NUM-1:0]     full;
    logic [CH_NUM-1:0]     empty;
    logic [CH_NUM-1:0]     ovf_set;
    logic                  load;

    assign wr_data[CH_A] = bus.a_i;
    assign wr_data[CH_B] = bus.b_i;
    assign wr_data[CH_C] = bus.c_i;
    assign wr_data[CH_D] = bus.d_i;
    assign push = {bus.d_valid_i, bus.c_valid_i, bus.b_valid_i, bus.a_valid_i};

    // Release only a complete tuple, and only into an empty or draining output register.
    assign load = (empty == '0) && (!bus.out_valid_o || bus.out_ready_i);

    // A write is lost only when its FIFO is full and this edge does not pop it.
    assign ovf_set = push & full & {CH_NUM{!load}};

    for (genvar g = 0; g < CH_NUM; g++) begin : g_chan
        chan_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_n   (artsn_i),
            .push    (push[g]),
            .pop     (load),
            .wr_data (wr_data[g]),
            .rd_data (rd_data[g]),
            .full    (full[g]),
            .empty   (empty[g]),
            .count   (fifo_count[g])
        );

        a_count_bound: assert property (@(posedge clk_i) disable iff (!artsn_i)
            fifo_count[g] <= CW'(DEPTH));
    end

    // Output register: load a new tuple, hold under backpressure, or drain when accepted.
    always_ff @(posedge clk_i or negedge artsn_i) begin
        if (!artsn_i) begin
            bus.out_valid_o <= 1'b0;
            bus.a_o         <= '0;
            bus.b_o         <= '0;
            bus.c_o         <= '0;
            bus.d_o         <= '0;
        end else if (load) begin
            bus.out_valid_o <= 1'b1;
            bus.a_o         <= rd_data[CH_A];
            bus.b_o         <= rd_data[CH_B];
            bus.c_o         <= rd_data[CH_C];
            bus.d_o         <= rd_data[CH_D];
        end else if (bus.out_ready_i) begin
            bus.out_valid_o <= 1'b0;
        end
    end

    // Sticky overflow flags; a new overflow beats a clear in the same cycle.
    always_ff @(posedge clk_i or negedge artsn_i) begin
        if (!artsn_i) begin
            bus.ovf_o <= '0;
        end else begin
            bus.ovf_o <= (bus.ovf_o & {CH_NUM{!bus.clear_err_i}}) | ovf_set;
        end
    end

endmodule

// File: tb/tb_operand_aligner.sv
// tb/tb_operand_aligner.sv - directed self-checking bench for operand_aligner
module tb_operand_aligner;
    import operand_aligner_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    operand_aligner_if #(.DATA_WIDTH(32)) bus ();

    operand_aligner #(.DATA_WIDTH(32), .DEPTH(4)) dut (
        .clk_i   (clk),
        .artsn_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        operand_t a, b, c, d;
        operand_t ea, eb, ec, ed;
    } vec_t;

    vec_t vecs [4];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_valid(input string nm, input logic exp);
        chk({nm, ".valid"}, {31'b0, bus.out_valid_o}, {31'b0, exp});
    endtask

    task automatic chk_ovf(input string nm, input logic [3:0] exp);
        chk({nm, ".ovf"}, {28'b0, bus.ovf_o}, {28'b0, exp});
    endtask

    task automatic chk_tuple(input string nm, input logic [31:0] a, b, c, d);
        chk_valid(nm, 1'b1);
        chk({nm, ".a"}, bus.a_o, a);
        chk({nm, ".b"}, bus.b_o, b);
        chk({nm, ".c"}, bus.c_o, c);
        chk({nm, ".d"}, bus.d_o, d);
    endtask

    task automatic drive(input logic va, vb, vc, vd, input logic [31:0] a, b, c, d);
        bus.a_valid_i = va;
        bus.b_valid_i = vb;
        bus.c_valid_i = vc;
        bus.d_valid_i = vd;
        bus.a_i = a;
        bus.b_i = b;
        bus.c_i = c;
        bus.d_i = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        logic [31:0] exp_a [4];
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.out_ready_i = 1'b1;
        bus.clear_err_i = 1'b0;
        idle();

        vecs[0] = '{a: 32'd10, b: 32'd4, c: 32'd2, d: 32'd1,
                    ea: 32'd10, eb: 32'd4, ec: 32'd2, ed: 32'd1};
        vecs[1] = '{a: 32'hFFFF_FFFF, b: 32'd0, c: 32'h8000_0001, d: 32'h1234_5678,
                    ea: 32'hFFFF_FFFF, eb: 32'd0, ec: 32'h8000_0001, ed: 32'h1234_5678};
        vecs[2] = '{a: 32'hDEAD_BEEF, b: 32'hCAFE_F00D, c: 32'h0000_0001, d: 32'h7FFF_FFFF,
                    ea: 32'hDEAD_BEEF, eb: 32'hCAFE_F00D, ec: 32'h0000_0001, ed: 32'h7FFF_FFFF};
        vecs[3] = '{a: 32'd0, b: 32'd0, c: 32'd0, d: 32'd0,
                    ea: 32'd0, eb: 32'd0, ec: 32'd0, ed: 32'd0};

        #12;
        chk_valid("reset", 1'b0);
        chk_ovf("reset", 4'b0000);
        chk("reset.a", bus.a_o, 32'd0);
        chk("reset.d", bus.d_o, 32'd0);
        rst_n = 1'b1;
        step();

        // Aligned tuples, including test 1 as entry 0.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b1, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d);
            step();
            idle();
            chk_valid($sformatf("vec%0d.nobypass", i), 1'b0);
            step();
            chk_tuple($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb, vecs[i].ec, vecs[i].ed);
            step();
            chk_valid($sformatf("vec%0d.drain", i), 1'b0);
        end

        // Skewed arrival: a@0, b@2, c@5, d@7.
        for (int e = 0; e <= 8; e++) begin
            idle();
            if (e == 0) begin bus.a_valid_i = 1'b1; bus.a_i = 32'd7; end
            if (e == 2) begin bus.b_valid_i = 1'b1; bus.b_i = 32'd3; end
            if (e == 5) begin bus.c_valid_i = 1'b1; bus.c_i = 32'd1; end
            if (e == 7) begin bus.d_valid_i = 1'b1; bus.d_i = 32'd2; end
            step();
            if (e < 8) chk_valid($sformatf("skew.e%0d", e), 1'b0);
            else       chk_tuple("skew", 32'd7, 32'd3, 32'd1, 32'd2);
        end
        idle();
        step();
        chk_valid("skew.drain", 1'b0);

        // Backpressure with three queued tuples.
        bus.out_ready_i = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'd1, 32'd2, 32'd3, 32'd4);
        step();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'd5, 32'd6, 32'd7, 32'd8);
        step();
        chk_tuple("bp.first", 32'd1, 32'd2, 32'd3, 32'd4);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'd9, 32'd10, 32'd11, 32'd12);
        step();
        idle();
        for (int i = 0; i < 6; i++) begin
            step();
            chk_tuple($sformatf("bp.hold%0d", i), 32'd1, 32'd2, 32'd3, 32'd4);
        end
        bus.out_ready_i = 1'b1;
        step();
        chk_tuple("bp.t2", 32'd5, 32'd6, 32'd7, 32'd8);
        step();
        chk_tuple("bp.t3", 32'd9, 32'd10, 32'd11, 32'd12);
        step();
        chk_valid("bp.drain", 1'b0);

        // Overflow on channel a, with clear colliding with the overflow.
        do_reset();
        step();
        bus.out_ready_i = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'd0, 32'd100, 32'd200, 32'd300);
        step();
        idle();
        for (int i = 1; i <= 6; i++) begin
            bus.a_valid_i = 1'b1;
            bus.a_i = i;
            bus.clear_err_i = (i == 6);
            step();
            if (i == 5) chk_ovf("ovf.before", 4'b0000);
        end
        idle();
        bus.clear_err_i = 1'b0;
        chk_ovf("ovf.set_beats_clear", 4'b0001);
        chk_tuple("ovf.outreg", 32'd1, 32'd100, 32'd200, 32'd300);
        step();
        chk_ovf("ovf.sticky", 4'b0001);
        bus.clear_err_i = 1'b1;
        step();
        bus.clear_err_i = 1'b0;
        chk_ovf("ovf.cleared", 4'b0000);

        // Full FIFO a: push and pop in the same edge.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'd0, 32'd101, 32'd201, 32'd301);
        step();
        bus.out_ready_i = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd7, 32'd0, 32'd0, 32'd0);
        step();
        chk_tuple("fullpp.t", 32'd2, 32'd101, 32'd201, 32'd301);
        chk_ovf("fullpp", 4'b0000);
        exp_a[0] = 32'd3;
        exp_a[1] = 32'd4;
        exp_a[2] = 32'd5;
        exp_a[3] = 32'd7;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b1, 32'd0, 32'd102 + i, 32'd202 + i, 32'd302 + i);
            step();
            if (i == 0) chk_valid("fullpp.gap", 1'b0);
            else chk_tuple($sformatf("fullpp.d%0d", i - 1), exp_a[i-1],
                           32'd101 + i, 32'd201 + i, 32'd301 + i);
        end
        idle();
        step();
        chk_tuple("fullpp.d3", exp_a[3], 32'd105, 32'd205, 32'd305);
        step();
        chk_valid("fullpp.drain", 1'b0);
        chk_ovf("fullpp.end", 4'b0000);

        // Reset mid-stream with buffered tuples and a pending overflow flag.
        bus.out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b1, 32'd50 + i, 32'd60 + i, 32'd70 + i, 32'd80 + i);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd90 + i, 32'd0, 32'd0, 32'd0);
            step();
        end
        idle();
        chk_ovf("rst.pre", 4'b0001);
        chk_tuple("rst.pre", 32'd50, 32'd60, 32'd70, 32'd80);
        #3;
        rst_n = 1'b0;
        #1;
        chk_valid("rst.async", 1'b0);
        chk_ovf("rst.async", 4'b0000);
        chk("rst.async.a", bus.a_o, 32'd0);
        #2;
        rst_n = 1'b1;
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_valid($sformatf("rst.stale%0d", i), 1'b0);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'd21, 32'd22, 32'd23, 32'd24);
        step();
        idle();
        chk_valid("rst.new.nobypass", 1'b0);
        step();
        chk_tuple("rst.new", 32'd21, 32'd22, 32'd23, 32'd24);
        step();
        chk_valid("rst.new.drain", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
